// File: rtl/mips_cpu_bus_arbiter.sv
// mips_cpu_bus_arbiter: two-master, one-slave Avalon-style bus arbiter; define MIPS_BUS_ARB_ROUND_ROBIN_EN for round-robin ties in IDLE
module mips_cpu_bus_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic [ADDR_W-1:0]   s_address,
  output logic                s_read,
  output logic                s_write,
  output logic [DATA_W-1:0]   s_writedata,
  output logic [DATA_W/8-1:0] s_byteenable,
  input  logic                s_waitrequest,
  input  logic [DATA_W-1:0]   s_readdata,
  output logic [1:0]          grant
);
  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;
`ifdef MIPS_BUS_ARB_ROUND_ROBIN_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif
  state_t state_q, state_d;
  logic   last_owner_q, last_owner_d;
  logic   req0, req1, tie_m1, own0, own1;
  assign req0   = m0_read | m0_write;
  assign req1   = m1_read | m1_write;
  assign tie_m1 = RR_EN & ~last_owner_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_owner_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
    end
  end
  // A completing owner hands straight to a waiting peer; otherwise back to IDLE
  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    case (state_q)
      IDLE:    state_d = (req0 & req1) ? (tie_m1 ? GRANT1 : GRANT0) :
                         req0 ? GRANT0 : req1 ? GRANT1 : IDLE;
      GRANT0: begin
        state_d      = !req0 ? IDLE : s_waitrequest ? GRANT0 : req1 ? GRANT1 : IDLE;
        last_owner_d = (req0 & ~s_waitrequest) ? 1'b0 : last_owner_q;
      end
      GRANT1: begin
        state_d      = !req1 ? IDLE : s_waitrequest ? GRANT1 : req0 ? GRANT0 : IDLE;
        last_owner_d = (req1 & ~s_waitrequest) ? 1'b1 : last_owner_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    own0           = state_q == GRANT0;
    own1           = state_q == GRANT1;
    grant          = {own1, own0};
    s_read         = own0 ? m0_read       : own1 ? m1_read       : 1'b0;
    s_write        = own0 ? m0_write      : own1 ? m1_write      : 1'b0;
    s_address      = own0 ? m0_address    : own1 ? m1_address    : '0;
    s_writedata    = own0 ? m0_writedata  : own1 ? m1_writedata  : '0;
    s_byteenable   = own0 ? m0_byteenable : own1 ? m1_byteenable : '0;
    m0_waitrequest = own0 ? s_waitrequest : 1'b1;
    m1_waitrequest = own1 ? s_waitrequest : 1'b1;
    m0_readdata    = s_readdata;
    m1_readdata    = s_readdata;
  end
endmodule
